// File: rtl/mem_io_responder.sv
// -----------------------------------------------------------------------------
// mem_io_responder
//
// Far-side responder for the multi-cycle CPU memory bus. Decodes the CPU
// address/strobes, serves a 60-byte RAM, and exposes memory-mapped I/O
// through an input FIFO (external producer -> CPU) and an output FIFO
// (CPU -> external consumer), each with a valid/ready handshake.
//
// Address map:
//   0x00-0x3B  RAM
//   0x3C       STATUS   (R: {2'b0, in_unf, out_ovf, out_full, out_empty,
//                            in_full, in_empty}; W: clears sticky bits)
//   0x3D       IN_COUNT (R)
//   0x3E       OUT_DATA (W: push output FIFO; R: 0x00)
//   0x3F       IN_DATA  (R: head of input FIFO, pops it)
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   adr_bus      in   [5:0] CPU address
//   rd_mem       in   CPU read request
//   wr_mem       in   CPU write request
//   data_bus_out in   [7:0] CPU write data
//   data_bus_in  out  [7:0] read data to CPU (combinational)
//   select       out  current read targets the I/O region
//   in_data      in   [7:0] producer data
//   in_valid     in   producer valid
//   in_ready     out  input FIFO not full
//   out_data     out  [7:0] output FIFO head, 0x00 when empty
//   out_valid    out  output FIFO not empty
//   out_ready    in   consumer ready
//
// IN_DEPTH / OUT_DEPTH must be powers of two in the range 2..8.
// -----------------------------------------------------------------------------
module mem_io_responder #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] adr_bus,
    input  logic       rd_mem,
    input  logic       wr_mem,
    input  logic [7:0] data_bus_out,
    output logic [7:0] data_bus_in,
    output logic       select,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int IN_CW  = IN_AW + 1;
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = OUT_AW + 1;

    localparam logic [5:0] RAM_TOP    = 6'h3B;
    localparam logic [5:0] ADR_STATUS = 6'h3C;
    localparam logic [5:0] ADR_INCNT  = 6'h3D;
    localparam logic [5:0] ADR_OUTDAT = 6'h3E;
    localparam logic [5:0] ADR_INDAT  = 6'h3F;

    // ------------------------------------------------------------------
    // Strobe edge detection
    // ------------------------------------------------------------------
    logic r_rd_q;
    logic r_wr_q;
    logic w_rd_ev;
    logic w_wr_ev;

    // A held strobe produces exactly one event; a read with wr_mem high
    // is not a read at all.
    assign w_rd_ev = rd_mem & ~r_rd_q & ~wr_mem;
    assign w_wr_ev = wr_mem & ~r_wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q <= 1'b0;
            r_wr_q <= 1'b0;
        end else begin
            r_rd_q <= rd_mem;
            r_wr_q <= wr_mem;
        end
    end

    // ------------------------------------------------------------------
    // RAM (not reset)
    // ------------------------------------------------------------------
    logic [7:0] r_ram [0:59];
    logic       w_ram_wr;

    assign w_ram_wr = w_wr_ev & (adr_bus <= RAM_TOP);

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[adr_bus] <= data_bus_out;
        end
    end

    // ------------------------------------------------------------------
    // Input FIFO (producer -> CPU)
    // ------------------------------------------------------------------
    logic [7:0]       r_in_mem [0:IN_DEPTH-1];
    logic [IN_AW-1:0] r_in_wptr;
    logic [IN_AW-1:0] r_in_rptr;
    logic [IN_CW-1:0] r_in_cnt;
    logic             w_in_empty;
    logic             w_in_full;
    logic             w_in_push;
    logic             w_in_pop;
    logic             w_in_rd;
    logic [7:0]       w_in_head;

    assign w_in_empty = (r_in_cnt == '0);
    assign w_in_full  = (r_in_cnt == IN_CW'(IN_DEPTH));
    assign in_ready   = ~w_in_full;
    // in_ready already excludes full, so a same-edge pop on a full FIFO
    // never lets a new entry in.
    assign w_in_push  = in_valid & ~w_in_full;
    assign w_in_rd    = w_rd_ev & (adr_bus == ADR_INDAT);
    assign w_in_pop   = w_in_rd & ~w_in_empty;
    assign w_in_head  = w_in_empty ? 8'h00 : r_in_mem[r_in_rptr];

    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_wptr <= '0;
            r_in_rptr <= '0;
            r_in_cnt  <= '0;
        end else begin
            if (w_in_push) begin
                r_in_wptr <= r_in_wptr + 1'b1;
            end
            if (w_in_pop) begin
                r_in_rptr <= r_in_rptr + 1'b1;
            end
            r_in_cnt <= r_in_cnt + IN_CW'(w_in_push) - IN_CW'(w_in_pop);
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (CPU -> consumer)
    // ------------------------------------------------------------------
    logic [7:0]        r_out_mem [0:OUT_DEPTH-1];
    logic [OUT_AW-1:0] r_out_wptr;
    logic [OUT_AW-1:0] r_out_rptr;
    logic [OUT_CW-1:0] r_out_cnt;
    logic              w_out_empty;
    logic              w_out_full;
    logic              w_out_wr;
    logic              w_out_push;
    logic              w_out_pop;

    assign w_out_empty = (r_out_cnt == '0);
    assign w_out_full  = (r_out_cnt == OUT_CW'(OUT_DEPTH));
    assign out_valid   = ~w_out_empty;
    assign out_data    = w_out_empty ? 8'h00 : r_out_mem[r_out_rptr];
    assign w_out_pop   = ~w_out_empty & out_ready;
    assign w_out_wr    = w_wr_ev & (adr_bus == ADR_OUTDAT);
    // A consumer pop on the same edge frees the slot the push needs, so a
    // write into a full FIFO is accepted when the pop coincides.
    assign w_out_push  = w_out_wr & (~w_out_full | w_out_pop);

    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_mem[r_out_wptr] <= data_bus_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_wptr <= '0;
            r_out_rptr <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_out_push) begin
                r_out_wptr <= r_out_wptr + 1'b1;
            end
            if (w_out_pop) begin
                r_out_rptr <= r_out_rptr + 1'b1;
            end
            r_out_cnt <= r_out_cnt + OUT_CW'(w_out_push) - OUT_CW'(w_out_pop);
        end
    end

    // ------------------------------------------------------------------
    // Sticky error bits
    // ------------------------------------------------------------------
    logic r_out_ovf;
    logic r_in_unf;
    logic w_ovf_set;
    logic w_unf_set;
    logic w_sticky_clr;

    assign w_ovf_set    = w_out_wr & ~w_out_push;
    assign w_unf_set    = w_in_rd & w_in_empty;
    assign w_sticky_clr = w_wr_ev & (adr_bus == ADR_STATUS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_ovf <= 1'b0;
            r_in_unf  <= 1'b0;
        end else if (w_sticky_clr) begin
            // Clear wins over a coincident set.
            r_out_ovf <= 1'b0;
            r_in_unf  <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_out_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_in_unf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    logic [7:0] w_status;
    logic [7:0] w_in_count;
    logic       w_rd_active;
    logic [7:0] w_rd_data;

    assign w_status    = {2'b00, r_in_unf, r_out_ovf, w_out_full, w_out_empty,
                          w_in_full, w_in_empty};
    assign w_in_count  = {{(8-IN_CW){1'b0}}, r_in_cnt};
    assign w_rd_active = rd_mem & ~wr_mem;

    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_active) begin
            if (adr_bus <= RAM_TOP) begin
                w_rd_data = r_ram[adr_bus];
            end else begin
                case (adr_bus)
                    ADR_STATUS: w_rd_data = w_status;
                    ADR_INCNT:  w_rd_data = w_in_count;
                    ADR_INDAT:  w_rd_data = w_in_head;
                    default:    w_rd_data = 8'h00;
                endcase
            end
        end
    end

    assign data_bus_in = w_rd_data;
    assign select      = w_rd_active & (adr_bus >= ADR_STATUS);

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] adr_bus;
    logic       rd_mem;
    logic       wr_mem;
    logic [7:0] data_bus_out;
    logic [7:0] data_bus_in;
    logic       select;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    mem_io_responder #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem),
        .wr_mem(wr_mem), .data_bus_out(data_bus_out), .data_bus_in(data_bus_in),
        .select(select), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    bit         m_ovf, m_unf, m_rdq, m_wrq;
    logic [7:0] m_ram [60];
    bit         m_ram_ok [60];

    function automatic void model_reset();
        in_q.delete();
        out_q.delete();
        m_ovf = 0; m_unf = 0; m_rdq = 0; m_wrq = 0;
    endfunction

    function automatic logic [7:0] exp_status();
        return {2'b00, m_unf, m_ovf, out_q.size() == OUT_DEPTH, out_q.size() == 0,
                in_q.size() == IN_DEPTH, in_q.size() == 0};
    endfunction

    function automatic logic [7:0] exp_dbi();
        if (!(rd_mem && !wr_mem)) return 8'h00;
        if (adr_bus < 6'd60) return m_ram[adr_bus];
        case (adr_bus)
            6'h3C: return exp_status();
            6'h3D: return 8'(in_q.size());
            6'h3F: return (in_q.size() == 0) ? 8'h00 : in_q[0];
            default: return 8'h00;
        endcase
    endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        bit rd_ev, wr_ev, in_push, in_pop, unf, out_pop, out_wr, ovf, clr;
        logic [7:0] din, dout;
        logic [5:0] a;
        int osz;
        rd_ev   = rd_mem && !m_rdq && !wr_mem;
        wr_ev   = wr_mem && !m_wrq;
        a       = adr_bus;
        din     = in_data;
        dout    = data_bus_out;
        in_push = in_valid && (in_q.size() < IN_DEPTH);
        in_pop  = rd_ev && a == 6'h3F && in_q.size() > 0;
        unf     = rd_ev && a == 6'h3F && in_q.size() == 0;
        out_pop = out_ready && out_q.size() > 0;
        out_wr  = wr_ev && a == 6'h3E;
        osz     = out_q.size() - (out_pop ? 1 : 0);
        ovf     = out_wr && osz >= OUT_DEPTH;
        clr     = wr_ev && a == 6'h3C;
        @(posedge clk);
        if (in_pop) void'(in_q.pop_front());
        if (in_push) in_q.push_back(din);
        if (out_pop) void'(out_q.pop_front());
        if (out_wr && !ovf) out_q.push_back(dout);
        if (clr) begin
            m_ovf = 0; m_unf = 0;
        end else begin
            if (ovf) m_ovf = 1;
            if (unf) m_unf = 1;
        end
        if (wr_ev && a < 6'd60) begin
            m_ram[a] = dout;
            m_ram_ok[a] = 1;
        end
        m_rdq = rd_mem;
        m_wrq = wr_mem;
        #1;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [7:0] d, output logic s);
        adr_bus = a; rd_mem = 1; wr_mem = 0;
        #1;
        d = data_bus_in; s = select;
        tick();
        rd_mem = 0;
        tick();
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
        adr_bus = a; data_bus_out = d; wr_mem = 1; rd_mem = 0;
        tick();
        wr_mem = 0;
        tick();
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (data_bus_in !== 8'h00 || select !== 1'b0 || in_ready !== 1'b1 ||
            out_valid !== 1'b0 || out_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got dbi=%h sel=%b in_rdy=%b out_vld=%b out_data=%h, need 00 0 1 0 00",
                     data_bus_in, select, in_ready, out_valid, out_data);
        end
        @(negedge clk);
        reset = 0;
        model_reset();
        tick();
    endtask

    task automatic test_ram_held();
        logic [7:0] d; logic s;
        // Held write to RAM, then held read
        adr_bus = 6'h10; data_bus_out = 8'hA5; wr_mem = 1;
        repeat (3) tick();
        wr_mem = 0; tick();
        rd_mem = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (data_bus_in !== 8'hA5 || select !== 1'b0) begin
                miscompares++;
                $display("FAIL ram_held_read[%0d]: got %h sel=%b, need A5 sel=0", i, data_bus_in, select);
            end
            tick();
        end
        rd_mem = 0; tick();
        // Held write to OUT_DATA must push exactly once
        adr_bus = 6'h3E; data_bus_out = 8'h5A; wr_mem = 1;
        repeat (3) tick();
        wr_mem = 0; tick();
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d !== 8'h01) begin
            miscompares++;
            $display("FAIL held_write_once: STATUS got %h, need 01", d);
        end
        out_ready = 1; #1;
        vectors++;
        if (out_data !== 8'h5A || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL held_write_data: got %h vld=%b, need 5A vld=1", out_data, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL held_write_single: out_valid got %b, need 0", out_valid);
        end
        out_ready = 0;
    endtask

    task automatic test_in_fifo();
        logic [7:0] d; logic s;
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = vals[i];
            tick();
        end
        in_data = 8'h99; #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL in_full_ready: got %b, need 0", in_ready);
        end
        cpu_read(6'h3D, d, s);
        vectors++;
        if (d !== 8'h04) begin
            miscompares++;
            $display("FAIL in_count_full: got %h, need 04", d);
        end
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL in_full_status: got %h, need bit1=1", d);
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_read(6'h3F, d, s);
            vectors++;
            if (d !== vals[i] || s !== 1'b1) begin
                miscompares++;
                $display("FAIL in_drain[%0d]: got %h sel=%b, need %h sel=1", i, d, s, vals[i]);
            end
        end
        cpu_read(6'h3D, d, s);
        vectors++;
        if (d !== 8'h00) begin
            miscompares++;
            $display("FAIL in_count_empty: got %h, need 00", d);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] d; logic s;
        cpu_read(6'h3F, d, s);
        vectors++;
        if (d !== 8'h00) begin
            miscompares++;
            $display("FAIL underflow_read: got %h, need 00", d);
        end
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d !== 8'h25) begin
            miscompares++;
            $display("FAIL underflow_status: got %h, need 25", d);
        end
        cpu_write(6'h3C, 8'h00);
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d !== 8'h05) begin
            miscompares++;
            $display("FAIL sticky_clear: got %h, need 05", d);
        end
    endtask

    task automatic test_out_overflow();
        logic [7:0] d; logic s;
        out_ready = 0;
        for (int i = 1; i <= 5; i++) cpu_write(6'h3E, 8'(i));
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d[4] !== 1'b1 || d[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_status: got %h, need bit4=1 bit3=1", d);
        end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vectors++;
            if (out_data !== 8'(i) || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL overflow_drain[%0d]: got %h vld=%b, need %h vld=1", i, out_data, out_valid, 8'(i));
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_lost: out_valid got %b, need 0", out_valid);
        end
        out_ready = 0;
        cpu_write(6'h3C, 8'hFF);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d; logic s;
        logic [7:0] exp [4];
        out_ready = 0;
        for (int i = 0; i < 4; i++) cpu_write(6'h3E, 8'h61 + 8'(i));
        out_ready = 1; adr_bus = 6'h3E; data_bus_out = 8'h77; wr_mem = 1;
        tick();
        out_ready = 0; wr_mem = 0;
        tick();
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d !== 8'h09) begin
            miscompares++;
            $display("FAIL full_push_pop_status: got %h, need 09", d);
        end
        exp[0] = 8'h62; exp[1] = 8'h63; exp[2] = 8'h64; exp[3] = 8'h77;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (out_data !== exp[i] || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL full_push_pop_drain[%0d]: got %h vld=%b, need %h", i, out_data, out_valid, exp[i]);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_push_pop_empty: out_valid got %b, need 0", out_valid);
        end
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic s;
        in_valid = 1; in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        in_valid = 0;
        cpu_write(6'h3E, 8'hD1);
        cpu_write(6'h3E, 8'hD2);
        adr_bus = 6'h3F; rd_mem = 1; wr_mem = 0;
        #1;
        vectors++;
        if (data_bus_in !== 8'hC1) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got %h, need C1", data_bus_in);
        end
        reset = 1;
        #1;
        model_reset();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_bus_in !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_async: got out_vld=%b in_rdy=%b dbi=%h, need 0 1 00",
                     out_valid, in_ready, data_bus_in);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        tick();
        rd_mem = 0;
        tick();
        cpu_read(6'h3C, d, s);
        vectors++;
        if (d !== 8'h25) begin
            miscompares++;
            $display("FAIL reset_release_event: STATUS got %h, need 25", d);
        end
        cpu_write(6'h3C, 8'h00);
    endtask

    task automatic test_random();
        int r;
        logic [7:0] e;
        bit chk;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                r = $urandom_range(0, 9);
                rd_mem = (r >= 4 && r <= 6) || r == 9;
                wr_mem = (r >= 7);
                adr_bus = ($urandom_range(0, 1) == 0) ? 6'(60 + $urandom_range(0, 3))
                                                      : 6'($urandom_range(0, 59));
                data_bus_out = 8'($urandom);
            end
            in_valid  = ($urandom_range(0, 2) == 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            #1;
            e = exp_dbi();
            chk = !(rd_mem && !wr_mem && adr_bus < 6'd60 && !m_ram_ok[adr_bus]);
            if (chk) begin
                vectors++;
                if (data_bus_in !== e) begin
                    miscompares++;
                    $display("FAIL rand_dbi[%0d]: adr=%h got %h, need %h", c, adr_bus, data_bus_in, e);
                end
            end
            vectors++;
            if (select !== (rd_mem && !wr_mem && adr_bus >= 6'h3C) ||
                in_ready !== (in_q.size() < IN_DEPTH) ||
                out_valid !== (out_q.size() > 0) ||
                out_data !== ((out_q.size() > 0) ? out_q[0] : 8'h00)) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got sel=%b in_rdy=%b out_vld=%b out_data=%h, need in_cnt=%0d out_cnt=%0d",
                         c, select, in_ready, out_valid, out_data, in_q.size(), out_q.size());
            end
            tick();
        end
        rd_mem = 0; wr_mem = 0; in_valid = 0; out_ready = 0;
        tick();
    endtask

    initial begin
        reset = 1; adr_bus = '0; rd_mem = 0; wr_mem = 0; data_bus_out = '0;
        in_data = '0; in_valid = 0; out_ready = 0;
        for (int i = 0; i < 60; i++) m_ram_ok[i] = 0;
        model_reset();
        test_reset();
        test_ram_held();
        test_in_fifo();
        test_underflow();
        test_out_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
